switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Per-output wormhole allocator for the 5-port mesh router.
- Takes one-hot direction requests and FIFO status from each input unit, plus downstream readiness per output.
- Grants each output to one input with round-robin fairness and holds the grant until that packet's tail flit passes.
- Drives input-FIFO read enables, crossbar selects and per-output flit valids.

Parameters:
- Num_Dir, 5, number of ports. Index 0 X+, 1 X-, 2 Y+, 3 Y-, 4 local.
- Sel_width, $clog2(Num_Dir), width of one crossbar select field.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- req_dir  input  Num_Dir*Num_Dir  request bits; bits [i*Num_Dir +: Num_Dir] are input i's one-hot requested output
- in_valid  input  Num_Dir  input i FIFO non-empty (head flit present)
- in_tail  input  Num_Dir  input i head flit is the packet's tail
- out_ready  input  Num_Dir  output o downstream can accept a flit this cycle
- read_en  output  Num_Dir  pop input i FIFO this cycle
- out_valid  output  Num_Dir  flit presented on output o this cycle
- xbar_sel  output  Num_Dir*Sel_width  bits [o*Sel_width +: Sel_width] give the input index routed to output o
- locked  output  Num_Dir  output o is currently owned by a packet

Behaviour:
- Request validity:
  - A request from input i counts only when in_valid[i]=1 and its req_dir slice has exactly one bit set.
  - A slice with zero or multiple bits set is ignored; that input is never granted.
- Per-output FSM, two states:
  - IDLE: locked[o]=0, out_valid[o]=0, xbar_sel[o]=0.
    - If any valid request targets o, the rr_arbiter picks the winner starting from ptr[o].
    - Next cycle: BUSY, owner[o] <= winner.
    - No flit moves in the allocation cycle, so head latency is 1 cycle from request to first transfer.
  - BUSY: locked[o]=1, xbar_sel[o]=owner[o] (registered).
    - Transfer condition: in_valid[owner] & out_ready[o].
    - On transfer: out_valid[o]=1 and read_en[owner]=1, both combinational in the same cycle.
    - Transfer with in_tail[owner]=1: next cycle IDLE, ptr[o] <= owner+1 (wraps Num_Dir-1 -> 0).
    - Transfer without tail: stay BUSY.
    - No transfer: stay BUSY, no pop, out_valid[o]=0. Bubbles from an empty FIFO or a stalled downstream never release the lock.
- Ownership rules:
  - An input requests one output at a time, so it owns at most one output.
  - read_en[i] = OR over outputs owned by i of that output's transfer condition.
  - An input already owning an output is excluded from arbitration elsewhere, even if its req_dir changes mid-packet.
- Round-robin:
  - Priority order is ptr, ptr+1, … mod Num_Dir.
  - ptr advances only on tail release, not on grant.
- Simultaneous events:
  - Output o releases (tail) in cycle t: a new grant can occur in cycle t+1 (IDLE evaluation). Minimum gap between packets is one cycle.
  - Several outputs may grant different inputs in the same cycle, and may grant in the same cycle one releases.
- Single-flit packet (head=tail): one allocation cycle, one transfer cycle, then IDLE.
- Reset:
  - Asserted at any clock edge, including mid-packet, all FSMs return to IDLE, all ptr=0, all owner=0.
  - All outputs are 0 during and after reset until a new grant.
  - Partially sent packets are abandoned. Flushing the FIFOs is the input unit's responsibility.
- No U-turn filtering: req_dir of input i targeting output i is honoured.

Decomposition:
- Shared package router_pkg:
  - Num_Dir.
  - Direction index constants DIR_XP=0, DIR_XM=1, DIR_YP=2, DIR_YM=3, DIR_LOCAL=4.
  - Sel_width.
- Sub-module rr_arbiter:
  - Combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once per output.
- Lock/owner/ptr registers and transfer logic stay in switch_allocator.

Test Plan:
- Reset idle: rst=1 for 3 cycles, then all inputs idle -> read_en=0, out_valid=0, locked=0, xbar_sel=0.
- Single packet: input 4 requests output 0 with a 3-flit packet (tail on flit 3), out_ready=1.
  - Cycle 1: locked[0]=1, xbar_sel[0]=4.
  - Cycles 1–3: read_en[4]=out_valid[0]=1.
  - Cycle 4: locked[0]=0.
- Contention fairness: inputs 1, 2, 3 each send 1-flit packets to output 4 continuously, ptr=0 -> grant order 1, 2, 3, 1, …, each packet taking 2 cycles.
- Wormhole hold: input 0 owns output 2 and in_valid[0] drops for 2 cycles mid-packet while input 1 requests output 2 -> output 2 stays locked to 0, read_en[1]=0 until input 0's tail transfers.
- Backpressure: out_ready[3]=0 for 4 cycles during input 2's packet -> no read_en[2], out_valid[3]=0, lock held; transfer resumes the cycle out_ready returns.
- Parallel + reset: input 0 -> output 1 and input 3 -> output 2 concurrently -> both transfer the same cycle. Assert rst mid-packet -> next cycle all locked=0, ptr=0.
- Malformed request: input 2 req_dir=5'b00011 -> never granted, no read_en[2].

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants: port count, direction indices, select width and
// the per-output allocation state.
package router_pkg;

    localparam int unsigned NUM_DIR   = 5;
    localparam int unsigned SEL_WIDTH = $clog2(NUM_DIR);

    localparam int unsigned DIR_XP    = 0;
    localparam int unsigned DIR_XM    = 1;
    localparam int unsigned DIR_YP    = 2;
    localparam int unsigned DIR_YM    = 3;
    localparam int unsigned DIR_LOCAL = 4;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_BUSY = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request found scanning
// ptr, ptr+1, ... (mod N) wins. Returns a one-hot grant and its index.
module rr_arbiter
    import router_pkg::*;
#(
    parameter int unsigned N  = NUM_DIR,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx
);

    // Rotating priority scan starting at ptr; first hit wins.
    always_comb begin
        int unsigned k;
        logic        found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            k = 32'(ptr) + off;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = SW'(k);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator. Each output is granted to one input
// with round-robin fairness and held until that packet's tail flit passes.
module switch_allocator
    import router_pkg::*;
#(
    parameter int unsigned Num_Dir   = NUM_DIR,
    parameter int unsigned Sel_width = $clog2(Num_Dir)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [Num_Dir*Num_Dir-1:0]     req_dir,
    input  logic [Num_Dir-1:0]             in_valid,
    input  logic [Num_Dir-1:0]             in_tail,
    input  logic [Num_Dir-1:0]             out_ready,
    output logic [Num_Dir-1:0]             read_en,
    output logic [Num_Dir-1:0]             out_valid,
    output logic [Num_Dir*Sel_width-1:0]   xbar_sel,
    output logic [Num_Dir-1:0]             locked
);

    out_state_e           state_q [Num_Dir];
    out_state_e           state_d [Num_Dir];
    logic [Sel_width-1:0] owner_q [Num_Dir];
    logic [Sel_width-1:0] owner_d [Num_Dir];
    logic [Sel_width-1:0] ptr_q   [Num_Dir];
    logic [Sel_width-1:0] ptr_d   [Num_Dir];

    logic [Num_Dir-1:0]   owns_any;
    logic [Num_Dir-1:0]   req_ok;
    logic [Num_Dir-1:0]   arb_req [Num_Dir];
    logic [Num_Dir-1:0]   arb_gnt [Num_Dir];
    logic [Sel_width-1:0] arb_idx [Num_Dir];

    // Eligible requests: valid head, one-hot direction, input not already owning an output.
    always_comb begin
        owns_any = '0;
        req_ok   = '0;
        for (int unsigned o = 0; o < Num_Dir; o++) begin
            if (state_q[o] == OUT_BUSY) begin
                owns_any[owner_q[o]] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < Num_Dir; i++) begin
            req_ok[i] = in_valid[i] & $onehot(req_dir[i*Num_Dir +: Num_Dir]) & ~owns_any[i];
        end
        for (int unsigned o = 0; o < Num_Dir; o++) begin
            arb_req[o] = '0;
            for (int unsigned i = 0; i < Num_Dir; i++) begin
                arb_req[o][i] = req_ok[i] & req_dir[i*Num_Dir + o];
            end
        end
    end

    for (genvar g = 0; g < Num_Dir; g++) begin : g_arb
        rr_arbiter #(
            .N  (Num_Dir),
            .SW (Sel_width)
        ) u_arb (
            .req (arb_req[g]),
            .ptr (ptr_q[g]),
            .gnt (arb_gnt[g]),
            .idx (arb_idx[g])
        );
    end

    // Per-output FSM next state plus transfer outputs; outputs held quiet while rst is high.
    always_comb begin
        logic xfer;
        read_en   = '0;
        out_valid = '0;
        xbar_sel  = '0;
        locked    = '0;
        xfer      = 1'b0;
        for (int unsigned o = 0; o < Num_Dir; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            xfer       = 1'b0;
            if (state_q[o] == OUT_BUSY) begin
                locked[o] = 1'b1;
                xbar_sel[o*Sel_width +: Sel_width] = owner_q[o];
                xfer = in_valid[owner_q[o]] & out_ready[o];
                out_valid[o] = xfer;
                if (xfer) begin
                    read_en[owner_q[o]] = 1'b1;
                end
                if (xfer && in_tail[owner_q[o]]) begin
                    state_d[o] = OUT_IDLE;
                    ptr_d[o]   = (owner_q[o] == Sel_width'(Num_Dir - 1)) ? '0 : owner_q[o] + 1'b1;
                end
            end else if (|arb_gnt[o]) begin
                state_d[o] = OUT_BUSY;
                owner_d[o] = arb_idx[o];
            end
        end
        if (rst) begin
            read_en   = '0;
            out_valid = '0;
            xbar_sel  = '0;
            locked    = '0;
        end
    end

    // State, owner and round-robin pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned o = 0; o < Num_Dir; o++) begin
                state_q[o] <= OUT_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
        end else begin
            for (int unsigned o = 0; o < Num_Dir; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: stimulus pushes expected outputs from
// a per-output ownership model; a negedge monitor pops and compares.
module tb_switch_allocator;

    localparam int N  = 5;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*N-1:0]  req_dir = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_tail = '0;
    logic [N-1:0]    out_ready = '0;
    logic [N-1:0]    read_en;
    logic [N-1:0]    out_valid;
    logic [N*SW-1:0] xbar_sel;
    logic [N-1:0]    locked;

    typedef struct packed {
        logic [N-1:0]    re;
        logic [N-1:0]    ov;
        logic [N*SW-1:0] xs;
        logic [N-1:0]    lk;
        int              cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   m_owner[N];   // -1 = output free
    int   m_ptr[N];

    switch_allocator #(.Num_Dir(N), .Sel_width(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_dir   (req_dir),
        .in_valid  (in_valid),
        .in_tail   (in_tail),
        .out_ready (out_ready),
        .read_en   (read_en),
        .out_valid (out_valid),
        .xbar_sel  (xbar_sel),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N*SW-1:0] got,
                         input logic [N*SW-1:0] want, input int c);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, c, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("read_en",   (N*SW)'(read_en),   (N*SW)'(e.re), e.cyc);
            check("out_valid", (N*SW)'(out_valid), (N*SW)'(e.ov), e.cyc);
            check("xbar_sel",  xbar_sel,           e.xs,          e.cyc);
            check("locked",    (N*SW)'(locked),    (N*SW)'(e.lk), e.cyc);
        end
    end

    // One clock of stimulus: drive, predict this cycle's outputs, advance the model.
    task automatic step(input logic r, input logic [N*N-1:0] rd, input logic [N-1:0] iv,
                        input logic [N-1:0] tl, input logic [N-1:0] ordy);
        exp_t e;
        int   nxt[N];
        bit   busy_in[N];
        int   i;
        bit   found;
        @(posedge clk);
        #1;
        rst = r; req_dir = rd; in_valid = iv; in_tail = tl; out_ready = ordy;
        e = '0;
        e.cyc = cyc;
        cyc++;
        if (r) begin
            for (int o = 0; o < N; o++) begin
                m_owner[o] = -1;
                m_ptr[o]   = 0;
            end
        end else begin
            for (int k = 0; k < N; k++) busy_in[k] = 1'b0;
            for (int o = 0; o < N; o++) begin
                nxt[o] = m_owner[o];
                if (m_owner[o] >= 0) busy_in[m_owner[o]] = 1'b1;
            end
            for (int o = 0; o < N; o++) begin
                if (m_owner[o] >= 0) begin
                    e.lk[o] = 1'b1;
                    e.xs[o*SW +: SW] = SW'(m_owner[o]);
                    if (iv[m_owner[o]] && ordy[o]) begin
                        e.ov[o] = 1'b1;
                        e.re[m_owner[o]] = 1'b1;
                        if (tl[m_owner[o]]) begin
                            nxt[o]   = -1;
                            m_ptr[o] = (m_owner[o] + 1) % N;
                        end
                    end
                end else begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        i = (m_ptr[o] + k) % N;
                        if (!found && iv[i] && !busy_in[i] &&
                            $countones(rd[i*N +: N]) == 1 && rd[i*N + o]) begin
                            found  = 1'b1;
                            nxt[o] = i;
                        end
                    end
                end
            end
            for (int o = 0; o < N; o++) m_owner[o] = nxt[o];
        end
        q.push_back(e);
    endtask

    function automatic logic [N*N-1:0] route(input int src, input int dst);
        logic [N*N-1:0] v;
        v = '0;
        v[src*N + dst] = 1'b1;
        return v;
    endfunction

    initial begin : stim
        logic [N*N-1:0] rd;
        logic [N-1:0]   iv, tl, ordy;
        logic [N-1:0]   dirs [N];
        int             waited;
        for (int o = 0; o < N; o++) begin
            m_owner[o] = -1;
            m_ptr[o]   = 0;
        end

        // Reset held three cycles, then idle.
        repeat (3) step(1'b1, '0, '0, '0, '0);
        repeat (2) step(1'b0, '0, '0, '0, 5'b11111);

        // Three-flit packet, input 4 -> output 0.
        step(1'b0, route(4, 0), 5'b10000, 5'b00000, 5'b11111);
        step(1'b0, route(4, 0), 5'b10000, 5'b00000, 5'b11111);
        step(1'b0, route(4, 0), 5'b10000, 5'b00000, 5'b11111);
        step(1'b0, route(4, 0), 5'b10000, 5'b10000, 5'b11111);
        repeat (2) step(1'b0, '0, '0, '0, 5'b11111);

        // Inputs 1,2,3 streaming single-flit packets at output 4.
        repeat (12) step(1'b0, route(1, 4) | route(2, 4) | route(3, 4), 5'b01110, 5'b01110, 5'b11111);
        repeat (2) step(1'b0, '0, '0, '0, 5'b11111);

        // Wormhole hold: input 0 owns output 2, goes empty while input 1 requests it.
        step(1'b0, route(0, 2), 5'b00001, 5'b00000, 5'b11111);
        step(1'b0, route(0, 2) | route(1, 2), 5'b00011, 5'b00000, 5'b11111);
        step(1'b0, route(0, 2) | route(1, 2), 5'b00010, 5'b00000, 5'b11111);
        step(1'b0, route(0, 2) | route(1, 2), 5'b00010, 5'b00000, 5'b11111);
        step(1'b0, route(0, 2) | route(1, 2), 5'b00011, 5'b00001, 5'b11111);
        repeat (3) step(1'b0, route(1, 2), 5'b00010, 5'b00010, 5'b11111);

        // Backpressure on output 3 during input 2's packet.
        step(1'b0, route(2, 3), 5'b00100, 5'b00000, 5'b11111);
        step(1'b0, route(2, 3), 5'b00100, 5'b00000, 5'b11111);
        repeat (4) step(1'b0, route(2, 3), 5'b00100, 5'b00000, 5'b10111);
        step(1'b0, route(2, 3), 5'b00100, 5'b00100, 5'b11111);
        step(1'b0, '0, '0, '0, 5'b11111);

        // Parallel packets, then reset mid-packet.
        repeat (3) step(1'b0, route(0, 1) | route(3, 2), 5'b01001, 5'b00000, 5'b11111);
        step(1'b1, route(0, 1) | route(3, 2), 5'b01001, 5'b00000, 5'b11111);
        repeat (2) step(1'b0, '0, '0, '0, 5'b11111);

        // Malformed request from input 2.
        rd = '0;
        rd[14:10] = 5'b00011;
        repeat (4) step(1'b0, rd, 5'b00100, 5'b00100, 5'b11111);

        // Randomised traffic with sticky directions and occasional malformed slices.
        for (int k = 0; k < N; k++) dirs[k] = 5'b00001 << $urandom_range(0, N - 1);
        for (int c = 0; c < 3000; c++) begin
            rd = '0;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 5))
                        0:       dirs[k] = '0;
                        1:       dirs[k] = 5'($urandom);
                        default: dirs[k] = 5'b00001 << $urandom_range(0, N - 1);
                    endcase
                end
                rd[k*N +: N] = dirs[k];
                iv[k]   = ($urandom_range(0, 3) != 0);
                tl[k]   = ($urandom_range(0, 2) == 0);
                ordy[k] = ($urandom_range(0, 4) != 0);
            end
            step(($urandom_range(0, 299) == 0), rd, iv, tl, ordy);
        end

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
